// File: rtl/alu_pkg.sv
// Shared ALU/branch types: ALU control codes, ARM condition codes,
// the NZCV flag bundle and the execute-result metadata bundle.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       taken;
    } ex_meta_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator over an NZCV snapshot.
module cond_eval
    import alu_pkg::*;
(
    input  cond_t  cond,
    input  flags_t flags,
    output logic   taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = ~flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = ~flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = ~flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = ~flags.v;
            COND_HI: taken = flags.c & ~flags.z;
            COND_LS: taken = ~flags.c | flags.z;
            COND_GE: taken = (flags.n == flags.v);
            COND_LT: taken = (flags.n != flags.v);
            COND_GT: taken = ~flags.z & (flags.n == flags.v);
            COND_LE: taken = flags.z | (flags.n != flags.v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_result_stage.sv
// Execute result stage: two-entry skid buffer for ALU results, owns the
// architectural NZCV flags and resolves conditional branches at accept.
module ex_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] aluOut,
    input  logic              negative,
    input  logic              zero,
    input  logic              overflow,
    input  logic              carryOut,
    input  logic              set_flags,
    input  logic              is_cbranch,
    input  logic [3:0]        cond,
    input  logic [4:0]        rd,
    input  logic              reg_write,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_taken,
    output logic [3:0]        flags_q
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_result;
    logic [DATA_W-1:0] skid_result;
    ex_meta_t          main_meta;
    ex_meta_t          skid_meta;
    ex_meta_t          in_meta;
    flags_t            flags_r;
    logic              cond_taken;
    logic              accept;
    logic              xfer;

    cond_eval u_cond_eval (
        .cond  (cond_t'(cond)),
        .flags (flags_r),
        .taken (cond_taken)
    );

    // Ready depends only on held state, never on out_ready.
    assign in_ready = ~skid_valid & ~reset;
    assign accept   = in_valid & in_ready & ~flush;
    assign xfer     = main_valid & out_ready;

    assign in_meta.rd        = rd;
    assign in_meta.reg_write = reg_write;
    assign in_meta.taken     = is_cbranch & cond_taken;

    assign out_valid     = main_valid;
    assign out_result    = main_result;
    assign out_rd        = main_meta.rd;
    assign out_reg_write = main_meta.reg_write;
    assign out_taken     = main_meta.taken;
    assign flags_q       = flags_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            main_result <= '0;
            skid_result <= '0;
            main_meta   <= '0;
            skid_meta   <= '0;
            flags_r     <= '0;
        end else begin
            if (accept && set_flags) begin
                flags_r <= '{n: negative, z: zero, c: carryOut, v: overflow};
            end
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (xfer && skid_valid) begin
                // in_ready is low here, so no accept can coincide.
                main_valid  <= 1'b1;
                main_result <= skid_result;
                main_meta   <= skid_meta;
                skid_valid  <= 1'b0;
            end else if (accept && (!main_valid || xfer)) begin
                main_valid  <= 1'b1;
                main_result <= aluOut;
                main_meta   <= in_meta;
            end else if (accept) begin
                skid_valid  <= 1'b1;
                skid_result <= aluOut;
                skid_meta   <= in_meta;
            end else if (xfer) begin
                main_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: handshake, skid, flush, flags and
// branch resolution, with hand-computed expectations.
module tb_ex_result_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] aluOut;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carryOut;
    logic        set_flags;
    logic        is_cbranch;
    logic [3:0]  cond;
    logic [4:0]  rd;
    logic        reg_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_taken;
    logic [3:0]  flags_q;

    int errors = 0;
    int checks = 0;

    ex_result_stage #(.DATA_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .aluOut        (aluOut),
        .negative      (negative),
        .zero          (zero),
        .overflow      (overflow),
        .carryOut      (carryOut),
        .set_flags     (set_flags),
        .is_cbranch    (is_cbranch),
        .cond          (cond),
        .rd            (rd),
        .reg_write     (reg_write),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_taken     (out_taken),
        .flags_q       (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] r, input logic [3:0] nzcv,
                         input logic sf, input logic cb, input logic [3:0] cd);
        in_valid   = 1'b1;
        aluOut     = r;
        negative   = nzcv[3];
        zero       = nzcv[2];
        carryOut   = nzcv[1];
        overflow   = nzcv[0];
        set_flags  = sf;
        is_cbranch = cb;
        cond       = cd;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        set_flags  = 1'b0;
        is_cbranch = 1'b0;
    endtask

    // One-cycle issue: drive, clock, then deassert.
    task automatic send(input logic [63:0] r, input logic [3:0] nzcv,
                        input logic sf, input logic cb, input logic [3:0] cd);
        drive(r, nzcv, sf, cb, cd);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        rd        = 5'd1;
        reg_write = 1'b1;
        aluOut    = '0;
        cond      = 4'd0;
        {negative, zero, carryOut, overflow} = 4'b0000;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_flags", 64'(flags_q), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_taken", 64'(out_taken), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ADD result 2, all flags clear
        send(64'd2, 4'b0000, 1'b1, 1'b0, 4'd0);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_result", out_result, 64'd2);
        chk("add_rd", 64'(out_rd), 64'd1);
        chk("add_flags", 64'(flags_q), 64'd0);
        @(posedge clk);
        #1;
        chk("add_drained", 64'(out_valid), 64'd0);

        // 0x7FFF..FF + 1: N=1, V=1
        send(64'h8000_0000_0000_0000, 4'b1001, 1'b1, 1'b0, 4'd0);
        chk("ovf_result", out_result, 64'h8000_0000_0000_0000);
        chk("ovf_flags", 64'(flags_q), 64'h9);
        send(64'd0, 4'b0000, 1'b0, 1'b1, 4'd11);
        chk("lt_valid", 64'(out_valid), 64'd1);
        chk("lt_taken", 64'(out_taken), 64'd0);
        send(64'd0, 4'b0000, 1'b0, 1'b1, 4'd4);
        chk("mi_taken", 64'(out_taken), 64'd1);
        send(64'd0, 4'b0000, 1'b0, 1'b0, 4'd14);
        chk("nobr_taken", 64'(out_taken), 64'd0);
        send(64'd0, 4'b0000, 1'b0, 1'b1, 4'd14);
        chk("al_taken", 64'(out_taken), 64'd1);
        chk("flags_kept", 64'(flags_q), 64'h9);
        @(posedge clk);
        #1;

        // Backpressure: 10, 20, 30 with out_ready low
        out_ready = 1'b0;
        drive(64'd10, 4'b0000, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        chk("bp_main", out_result, 64'd10);
        chk("bp_ready1", 64'(in_ready), 64'd1);
        drive(64'd20, 4'b0000, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        drive(64'd30, 4'b0000, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        chk("bp_stable", out_result, 64'd10);
        chk("bp_ready3", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("emit0", out_result, 64'd10);
        @(posedge clk);
        #1;
        chk("emit1", out_result, 64'd20);
        chk("emit1_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        idle();
        chk("emit2", out_result, 64'd30);
        chk("emit2_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush with both entries held
        out_ready = 1'b0;
        send(64'd40, 4'b0000, 1'b0, 1'b0, 4'd0);
        send(64'd50, 4'b0000, 1'b0, 1'b0, 4'd0);
        chk("fl_full", 64'(in_ready), 64'd0);
        drive(64'd60, 4'b0110, 1'b1, 1'b0, 4'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_flags", 64'(flags_q), 64'h9);
        chk("fl_ready", 64'(in_ready), 64'd1);

        // Flush with room: incoming entry and flag update suppressed
        send(64'd70, 4'b0000, 1'b0, 1'b0, 4'd0);
        drive(64'd80, 4'b0110, 1'b1, 1'b0, 4'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        chk("fl2_valid", 64'(out_valid), 64'd0);
        chk("fl2_flags", 64'(flags_q), 64'h9);

        // SUBS 5-5: Z=1, C=1, then branches back-to-back
        out_ready = 1'b1;
        send(64'd0, 4'b0110, 1'b1, 1'b0, 4'd0);
        chk("subs_flags", 64'(flags_q), 64'h6);
        send(64'd0, 4'b0000, 1'b0, 1'b1, 4'd0);
        chk("eq_taken", 64'(out_taken), 64'd1);
        send(64'd0, 4'b0000, 1'b0, 1'b1, 4'd1);
        chk("ne_taken", 64'(out_taken), 64'd0);
        send(64'd0, 4'b0000, 1'b0, 1'b1, 4'd8);
        chk("hi_taken", 64'(out_taken), 64'd0);
        send(64'd0, 4'b0000, 1'b0, 1'b1, 4'd10);
        chk("ge_taken", 64'(out_taken), 64'd1);
        @(posedge clk);
        #1;

        // Reset with an entry held
        out_ready = 1'b0;
        send(64'd77, 4'b1000, 1'b1, 1'b0, 4'd0);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_flags", 64'(flags_q), 64'h8);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_flags", 64'(flags_q), 64'd0);
        chk("mid_rst_result", out_result, 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_empty", 64'(out_valid), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, result width.
REQ-002 SHALL have clk  input  1  rising-edge clock; reset is asynchronous and active-high, port reset.
REQ-003 SHALL have reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have in_valid  input  1  upstream ALU result valid.
REQ-005 SHALL have in_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have aluOut  input  DATA_W  ALU result.
REQ-007 SHALL have negative, zero, overflow, carryOut  input  1 each  ALU flags.
REQ-008 SHALL have set_flags  input  1  instruction updates NZCV.
REQ-009 SHALL have is_cbranch, cond  input  1, 4  conditional branch and ARM cond code.
REQ-010 SHALL have rd, reg_write  input  5, 1  destination register and write enable.
REQ-011 SHALL have flush  input  1  discard all held and incoming entries.
REQ-012 SHALL have out_valid, out_ready  output 1, input 1  downstream handshake.
REQ-013 SHALL have out_result, out_rd, out_reg_write, out_taken  output  DATA_W, 5, 1, 1  held entry.
REQ-014 SHALL have flags_q  output  4  architectural NZCV, bit3=N..bit0=V order N,Z,C,V.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready && !flush; transfer out when out_valid && out_ready.
REQ-016 SHALL hold two entries: main (drives outputs) and skid; in_ready SHALL equal !skid_valid, registered, no combinational path from out_ready.
REQ-017 SHALL, on accept into empty main or with main draining same cycle, write main; otherwise write skid.
REQ-018 SHALL, on transfer with skid valid, move skid to main next cycle.
REQ-019 SHALL preserve acceptance order; latency input-to-output one cycle when empty.
REQ-020 SHALL update flags_q to {negative,zero,carryOut,overflow} on accept with set_flags=1, visible next cycle.
REQ-021 SHALL compute out_taken at accept from flags_q before that instruction's own update: EQ 0 Z, NE 1 !Z, HS 2 C, LO 3 !C, MI 4 N, PL 5 !N, VS 6 V, VC 7 !V, HI 8 C&!Z, LS 9 !C|Z, GE 10 N==V, LT 11 N!=V, GT 12 !Z&(N==V), LE 13 Z|(N!=V), 14/15 always.
REQ-022 SHALL force out_taken=0 when is_cbranch=0.
REQ-023 SHALL, on flush, clear main and skid valid next cycle, suppress same-cycle accept and flag update; flags_q unchanged.
REQ-024 SHALL, on flush coincident with transfer, still count transfer complete downstream.
REQ-025 SHALL hold outputs stable while out_valid && !out_ready.
REQ-026 SHALL drive out_result etc. from main regardless of out_valid; consumers qualify with out_valid.

Reset
REQ-027 SHALL, while reset high, drive out_valid=0, in_ready=0, flags_q=0, out_result=0, out_rd=0, out_reg_write=0, out_taken=0.
REQ-028 SHALL, first cycle after reset release, assert in_ready=1.
REQ-029 SHALL, on reset mid-transfer, drop all entries without emitting them.

Structure
REQ-030 SHALL place ALU ctrl constants (PASS_B 000, ADD 010, SUB 011, AND 100, OR 101, XOR 110), cond_t enum and flags_t NZCV struct in shared package alu_pkg.
REQ-031 SHALL implement condition evaluation as combinational sub-module cond_eval (cond, flags -> taken).

Verification
REQ-032 Bench SHALL: reset, then ADD result 2 set_flags=1, out_ready=1 -> out_valid next cycle, out_result=2, flags_q=0000.
REQ-033 Bench SHALL: accept 0x7FFFFFFFFFFFFFFF+1 flags N=1,V=1 set_flags, then B.cond LT (11) -> out_taken=0; B.cond MI (4) -> out_taken=1.
REQ-034 Bench SHALL: out_ready=0, stream 3 results 10,20,30 -> 2 accepted, in_ready=0 third cycle; release out_ready -> 10,20,30 emitted in order, none lost.
REQ-035 Bench SHALL: flush with both entries full and in_valid=1 set_flags=1 -> out_valid=0 next cycle, flags_q unchanged.
REQ-036 Bench SHALL: SUBS 5-5 (Z=1,C=1) followed same-cadence by B.cond EQ -> out_taken=1; B.cond NE same flags -> 0.
REQ-037 Bench SHALL: assert reset with entry held -> out_valid=0 immediately, flags_q=0.
